// File: rtl/tlc_vehicle_sensor_pkg.sv
// Shared types and default parameters for the vehicle-sensor request path.
// The lane FSM encoding is fixed so the controller and debug tools agree on it.
package tlc_vehicle_sensor_pkg;

  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_PASS_CYCLES = 8;
  localparam int DEF_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SERVE = 2'd2
  } lane_state_e;

  // A lane asks the controller for service whenever it holds queued vehicles.
  function automatic logic lane_requesting(input lane_state_e st);
    return st != IDLE;
  endfunction

endpackage

// File: rtl/tlc_vehicle_sensor_if.sv
// Sensor-side bundle between loop detectors, this block and the light controller.
// Also carries per-lane FSM state for debug visibility.
interface tlc_vehicle_sensor_if #(
    parameter int CNT_W = 4
);
    import tlc_vehicle_sensor_pkg::*;

    // Request/grant semantics: s_x is a level request that rises when a vehicle
    // is queued and stays high until the queue is empty; Gx is the controller's
    // green level and is not an acknowledge -- every PASS_CYCLES green cycles
    // retire one vehicle, and the request drops on the edge that empties the queue.
    logic             raw_a;
    logic             raw_b;
    logic             Ga;
    logic             Gb;
    logic             s_a;
    logic             s_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             ovf_a;
    logic             ovf_b;
    lane_state_e      state_a;
    lane_state_e      state_b;

    modport master (
        input  raw_a, raw_b, Ga, Gb,
        output s_a, s_b, cnt_a, cnt_b, ovf_a, ovf_b, state_a, state_b
    );

    modport slave (
        output raw_a, raw_b, Ga, Gb,
        input  s_a, s_b, cnt_a, cnt_b, ovf_a, ovf_b, state_a, state_b
    );

endinterface

// File: rtl/tlc_vehicle_sensor_lane.sv
// One direction: synchronise and debounce the loop detector, count queued
// vehicles, retire them under green, and hold the service request meanwhile.
module tlc_vehicle_sensor_lane
    import tlc_vehicle_sensor_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int PASS_CYCLES = DEF_PASS_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             raw,
    input  logic             green,
    output logic             req,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output lane_state_e      state
);

    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int PW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0]    PASS_LAST = PW'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             sync1;
    logic             sync2;
    logic             deb_level;
    logic             deb_prev;
    logic [DW-1:0]    deb_cnt;
    logic [PW-1:0]    pass_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_q;
    logic             ovf_nxt;
    logic             req_q;
    logic             arrival;
    logic             departure;
    lane_state_e      state_q;
    lane_state_e      state_nxt;

    // Front end: synchroniser, debounce filter and edge detector.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb_level;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= ~deb_level;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Pass counter only advances under green; any red cycle restarts it.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pass_cnt <= '0;
        end else if (!green) begin
            pass_cnt <= '0;
        end else if (pass_cnt == PASS_LAST) begin
            pass_cnt <= '0;
        end else begin
            pass_cnt <= pass_cnt + 1'b1;
        end
    end

    always_comb begin
        arrival   = deb_level & ~deb_prev;
        departure = green && (pass_cnt == PASS_LAST) && (cnt_q != '0);

        cnt_nxt = cnt_q;
        ovf_nxt = ovf_q;
        if (arrival && !departure) begin
            if (cnt_q == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end else if (departure && !arrival) begin
            cnt_nxt = cnt_q - 1'b1;
        end
    end

    // Transitions look at the post-update count so the request drops together
    // with the departure that empties the queue.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (arrival) begin
                    state_nxt = green ? SERVE : WAIT;
                end
            end
            WAIT: begin
                if (green) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (cnt_nxt == '0) begin
                    state_nxt = IDLE;
                end else if (!green) begin
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            ovf_q   <= ovf_nxt;
            req_q   <= lane_requesting(state_nxt);
        end
    end

    assign req   = req_q;
    assign cnt   = cnt_q;
    assign ovf   = ovf_q;
    assign state = state_q;

endmodule

// File: rtl/tlc_vehicle_sensor.sv
// Request side of the light controller's sensor interface: two independent
// lanes, A and B, each fed back with its own green signal.
module tlc_vehicle_sensor
    import tlc_vehicle_sensor_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int PASS_CYCLES = DEF_PASS_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  res,
    tlc_vehicle_sensor_if.master bus
);

    tlc_vehicle_sensor_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .PASS_CYCLES(PASS_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane_a (
        .clk  (clk),
        .res  (res),
        .raw  (bus.raw_a),
        .green(bus.Ga),
        .req  (bus.s_a),
        .cnt  (bus.cnt_a),
        .ovf  (bus.ovf_a),
        .state(bus.state_a)
    );

    tlc_vehicle_sensor_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .PASS_CYCLES(PASS_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane_b (
        .clk  (clk),
        .res  (res),
        .raw  (bus.raw_b),
        .green(bus.Gb),
        .req  (bus.s_b),
        .cnt  (bus.cnt_b),
        .ovf  (bus.ovf_b),
        .state(bus.state_b)
    );

endmodule

// File: tb/tb_tlc_vehicle_sensor.sv
// Directed bench for tlc_vehicle_sensor: a vector table for the lane behaviour
// plus hand-written sequences for reset, saturation and arrival/departure collision.
module tb_tlc_vehicle_sensor;
  import tlc_vehicle_sensor_pkg::*;

  localparam int CNT_W = 4;

  typedef struct {
    logic             raw_a;
    logic             raw_b;
    logic             ga;
    logic             gb;
    int               cycles;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             s_a;
    logic             s_b;
    lane_state_e      st_a;
    lane_state_e      st_b;
  } vec_t;

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  logic [CNT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tlc_vehicle_sensor_if #(.CNT_W(CNT_W)) bus ();

  tlc_vehicle_sensor #(
    .DEB_CYCLES (4),
    .PASS_CYCLES(8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus.master)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string tag,
                             input logic [CNT_W-1:0] cnt_a, input logic [CNT_W-1:0] cnt_b,
                             input logic s_a, input logic s_b,
                             input lane_state_e st_a, input lane_state_e st_b,
                             input logic ovf_a, input logic ovf_b);
    check({tag, ".cnt_a"}, 32'(bus.cnt_a), 32'(cnt_a));
    check({tag, ".cnt_b"}, 32'(bus.cnt_b), 32'(cnt_b));
    check({tag, ".s_a"}, 32'(bus.s_a), 32'(s_a));
    check({tag, ".s_b"}, 32'(bus.s_b), 32'(s_b));
    check({tag, ".state_a"}, 32'(bus.state_a), 32'(st_a));
    check({tag, ".state_b"}, 32'(bus.state_b), 32'(st_b));
    check({tag, ".ovf_a"}, 32'(bus.ovf_a), 32'(ovf_a));
    check({tag, ".ovf_b"}, 32'(bus.ovf_b), 32'(ovf_b));
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  function automatic vec_t v(input logic ra, input logic rb, input logic ga, input logic gb,
                             input int cyc, input logic [CNT_W-1:0] ca, input logic [CNT_W-1:0] cb,
                             input logic sa, input logic sb, input lane_state_e sta, input lane_state_e stb);
    vec_t r;
    r.raw_a = ra; r.raw_b = rb; r.ga = ga; r.gb = gb; r.cycles = cyc;
    r.cnt_a = ca; r.cnt_b = cb; r.s_a = sa; r.s_b = sb; r.st_a = sta; r.st_b = stb;
    return r;
  endfunction

  task automatic drive(input logic ra, input logic rb, input logic ga, input logic gb);
    bus.raw_a = ra;
    bus.raw_b = rb;
    bus.Ga    = ga;
    bus.Gb    = gb;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // One clean vehicle: detector high 8 cycles, then low 8 cycles.
  task automatic car(input bit lane_b);
    if (lane_b) bus.raw_b = 1'b1; else bus.raw_a = 1'b1;
    run_edges(8);
    if (lane_b) bus.raw_b = 1'b0; else bus.raw_a = 1'b0;
    run_edges(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    res = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // raw_a raw_b Ga Gb cycles | cnt_a cnt_b s_a s_b state_a state_b
    vecs.push_back(v(0, 0, 0, 0,  2, 0, 0, 0, 0, IDLE,  IDLE));
    // single car on B: request exactly 7 edges after first sample
    vecs.push_back(v(0, 1, 0, 0,  6, 0, 0, 0, 0, IDLE,  IDLE));
    vecs.push_back(v(0, 1, 0, 0,  1, 0, 1, 0, 1, IDLE,  WAIT));
    vecs.push_back(v(0, 1, 0, 0, 13, 0, 1, 0, 1, IDLE,  WAIT));
    vecs.push_back(v(0, 0, 0, 0,  8, 0, 1, 0, 1, IDLE,  WAIT));
    // 3-cycle glitch on A is filtered
    vecs.push_back(v(1, 0, 0, 0,  3, 0, 1, 0, 1, IDLE,  WAIT));
    vecs.push_back(v(0, 0, 0, 0, 10, 0, 1, 0, 1, IDLE,  WAIT));
    // second car on B
    vecs.push_back(v(0, 1, 0, 0,  8, 0, 2, 0, 1, IDLE,  WAIT));
    vecs.push_back(v(0, 0, 0, 0,  8, 0, 2, 0, 1, IDLE,  WAIT));
    // drain B under green; IDLE while Gb still high
    vecs.push_back(v(0, 0, 0, 1,  7, 0, 2, 0, 1, IDLE,  SERVE));
    vecs.push_back(v(0, 0, 0, 1,  1, 0, 1, 0, 1, IDLE,  SERVE));
    vecs.push_back(v(0, 0, 0, 1,  7, 0, 1, 0, 1, IDLE,  SERVE));
    vecs.push_back(v(0, 0, 0, 1,  1, 0, 0, 0, 0, IDLE,  IDLE));
    vecs.push_back(v(0, 0, 0, 1,  4, 0, 0, 0, 0, IDLE,  IDLE));
    vecs.push_back(v(0, 0, 0, 0,  2, 0, 0, 0, 0, IDLE,  IDLE));
    // three cars on A
    vecs.push_back(v(1, 0, 0, 0,  8, 1, 0, 1, 0, WAIT,  IDLE));
    vecs.push_back(v(0, 0, 0, 0,  8, 1, 0, 1, 0, WAIT,  IDLE));
    vecs.push_back(v(1, 0, 0, 0,  8, 2, 0, 1, 0, WAIT,  IDLE));
    vecs.push_back(v(0, 0, 0, 0,  8, 2, 0, 1, 0, WAIT,  IDLE));
    vecs.push_back(v(1, 0, 0, 0,  8, 3, 0, 1, 0, WAIT,  IDLE));
    vecs.push_back(v(0, 0, 0, 0,  8, 3, 0, 1, 0, WAIT,  IDLE));
    // partial serve: 10 green cycles retire one car, pass counter restarts
    vecs.push_back(v(0, 0, 1, 0, 10, 2, 0, 1, 0, SERVE, IDLE));
    vecs.push_back(v(0, 0, 0, 0,  1, 2, 0, 1, 0, WAIT,  IDLE));
    vecs.push_back(v(0, 0, 1, 0,  7, 2, 0, 1, 0, SERVE, IDLE));
    vecs.push_back(v(0, 0, 1, 0,  1, 1, 0, 1, 0, SERVE, IDLE));
    vecs.push_back(v(0, 0, 0, 0,  2, 1, 0, 1, 0, WAIT,  IDLE));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_lanes("reset_hold", 0, 0, 0, 0, IDLE, IDLE, 0, 0);
    res = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].raw_a, vecs[i].raw_b, vecs[i].ga, vecs[i].gb);
      run_edges(vecs[i].cycles);
      check_lanes($sformatf("vec%0d", i), vecs[i].cnt_a, vecs[i].cnt_b,
                  vecs[i].s_a, vecs[i].s_b, vecs[i].st_a, vecs[i].st_b, 1'b0, 1'b0);
    end

    // ---- mid-run asynchronous reset with cnt_a = 3 ----
    car(1'b0);
    car(1'b0);
    check_lanes("pre_reset", 3, 0, 1, 0, WAIT, IDLE, 0, 0);
    #2 res = 1'b1;
    #1 check_lanes("async_reset", 0, 0, 0, 0, IDLE, IDLE, 0, 0);
    @(negedge clk);
    res = 1'b0;
    run_edges(10);
    check_lanes("post_reset", 0, 0, 0, 0, IDLE, IDLE, 0, 0);

    // ---- saturation on A: 16 arrivals into a 15-deep counter ----
    for (int i = 0; i < 16; i++) exp_q.push_back((i < 15) ? CNT_W'(i + 1) : CNT_W'(15));
    for (int i = 0; i < 16; i++) begin
      logic [CNT_W-1:0] exp_cnt;
      car(1'b0);
      exp_cnt = exp_q.pop_front();
      check($sformatf("sat_cnt_a%0d", i), 32'(bus.cnt_a), 32'(exp_cnt));
      check($sformatf("sat_ovf_a%0d", i), 32'(bus.ovf_a), (i == 15) ? 32'd1 : 32'd0);
    end
    check_lanes("saturated", 15, 0, 1, 0, WAIT, IDLE, 1, 0);

    // ---- arrival coinciding with departure on B ----
    car(1'b1);
    check_lanes("coll_setup", 15, 1, 1, 1, WAIT, WAIT, 1, 0);
    bus.Gb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.raw_b = 1'b1;
    run_edges(6);
    check_lanes("coll_before", 15, 1, 1, 1, WAIT, SERVE, 1, 0);
    run_edges(1);
    check_lanes("coll_edge", 15, 1, 1, 1, WAIT, SERVE, 1, 0);
    run_edges(7);
    check_lanes("coll_after", 15, 1, 1, 1, WAIT, SERVE, 1, 0);
    run_edges(1);
    check_lanes("coll_drain", 15, 0, 1, 0, WAIT, IDLE, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    run_edges(8);
    check_lanes("final", 15, 0, 1, 0, WAIT, IDLE, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
